// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM state encoding,
// parity mode constants and the 2-of-3 majority vote used for bit decisions.
package uart_pkg;

  // Receiver FSM state encoding (fixed; other blocks may decode it).
  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StStart    = 3'd1;
  localparam logic [2:0] StData     = 3'd2;
  localparam logic [2:0] StParity   = 3'd3;
  localparam logic [2:0] StStop     = 3'd4;
  localparam logic [2:0] StWaitHigh = 3'd5;

  // Parity modes for the PARITY parameter.
  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-slot timer and 3-point sampler for the UART receiver.
// Ports:
//   clock, reset       - clock, synchronous active-high reset
//   lineIn             - synchronized serial line
//   countEn, countClr  - advance / clear the slot counter (clear wins)
//   bitValue           - majority of samples at M-1, M and M+1 (valid with midDone)
//   midDone            - strobe at count M+1, where the bit is decided
//   slotEnd            - strobe on the last count of the slot
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_POR_BIT = 5209
) (
  input  logic clock,
  input  logic reset,
  input  logic lineIn,
  input  logic countEn,
  input  logic countClr,
  output logic bitValue,
  output logic midDone,
  output logic slotEnd
);

  localparam int unsigned CntW = $clog2(CLOCKS_POR_BIT);
  localparam int unsigned Mid  = (CLOCKS_POR_BIT - 1) / 2;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            s0_q, s1_q;

  always_comb begin
    cnt_d = cnt_q;
    if (countClr) begin
      cnt_d = '0;
    end else if (countEn) begin
      cnt_d = (cnt_q == CntW'(CLOCKS_POR_BIT - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      s0_q  <= 1'b1;
      s1_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      if (cnt_q == CntW'(Mid - 1)) s0_q <= lineIn;
      if (cnt_q == CntW'(Mid))     s1_q <= lineIn;
    end
  end

  assign midDone  = (cnt_q == CntW'(Mid + 1));
  assign slotEnd  = (cnt_q == CntW'(CLOCKS_POR_BIT - 1));
  // Third sample is taken live on the decision cycle.
  assign bitValue = maj3(s0_q, s1_q, lineIn);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: start/data/parity/stop framing with majority
// sampling, parity/framing/break detection and early stop-bit resync.
// Ports:
//   clock, reset   - clock, synchronous active-high reset
//   serialIn       - asynchronous serial input, idle high
//   dataOut        - last received word (LSB first on the wire)
//   dataValid      - one-cycle pulse per completed frame
//   parityError    - parity mismatch of last frame
//   framingError   - a stop bit of last frame sampled low
//   breakDetected  - last frame all zero, including parity and stop
//   rxBusy         - reception in progress (FSM not idle)
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_POR_BIT = 5209,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned PARITY         = 0,
  parameter int unsigned STOP_BITS      = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 serialIn,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 dataValid,
  output logic                 parityError,
  output logic                 framingError,
  output logic                 breakDetected,
  output logic                 rxBusy
);

  localparam int unsigned BitCntW = $clog2(DATA_BITS + 1);

  logic                 sync1_q, sync2_q;
  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 any_one_q, any_one_d;
  logic                 stop_low_q, stop_low_d;
  logic                 par_bad_q, par_bad_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;
  logic                 valid_q, valid_d;
  logic                 busy_q;

  logic bit_value, mid_done, slot_end;
  logic cnt_en, cnt_clr;
  logic par_ok, last_stop;

  uart_rx_sampler #(
    .CLOCKS_POR_BIT(CLOCKS_POR_BIT)
  ) u_sampler (
    .clock   (clock),
    .reset   (reset),
    .lineIn  (sync2_q),
    .countEn (cnt_en),
    .countClr(cnt_clr),
    .bitValue(bit_value),
    .midDone (mid_done),
    .slotEnd (slot_end)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    any_one_d  = any_one_q;
    stop_low_d = stop_low_q;
    par_bad_d  = par_bad_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    valid_d    = 1'b0;
    cnt_en     = 1'b1;
    cnt_clr    = 1'b0;
    par_ok     = ((PARITY == PAR_EVEN) && (bit_value == ^shift_q)) ||
                 ((PARITY == PAR_ODD)  && (bit_value != ^shift_q));
    last_stop  = (stop_cnt_q == 1'(STOP_BITS - 1));

    case (state_q)
      StIdle: begin
        cnt_en  = 1'b0;
        cnt_clr = 1'b1;
        // The detection cycle itself is count 0 of the start slot.
        if (!sync2_q) begin
          cnt_en     = 1'b1;
          cnt_clr    = 1'b0;
          state_d    = StStart;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          any_one_d  = 1'b0;
          stop_low_d = 1'b0;
          par_bad_d  = 1'b0;
        end
      end
      StStart: begin
        if (mid_done && bit_value) begin
          state_d = StIdle;
          cnt_clr = 1'b1;
        end else if (slot_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (mid_done) begin
          shift_d   = {bit_value, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          any_one_d = any_one_q | bit_value;
        end
        if (slot_end && (bit_cnt_q == BitCntW'(DATA_BITS))) begin
          state_d = (PARITY != PAR_NONE) ? StParity : StStop;
        end
      end
      StParity: begin
        if (mid_done) begin
          par_bad_d = ~par_ok;
          any_one_d = any_one_q | bit_value;
        end
        if (slot_end) state_d = StStop;
      end
      StStop: begin
        if (mid_done) begin
          if (last_stop) begin
            // Decide at mid-slot so a back-to-back start edge is not missed.
            data_d  = shift_q;
            perr_d  = par_bad_q;
            ferr_d  = stop_low_q | ~bit_value;
            brk_d   = ~(any_one_q | bit_value);
            valid_d = 1'b1;
            cnt_clr = 1'b1;
            state_d = (stop_low_q | ~bit_value) ? StWaitHigh : StIdle;
          end else begin
            stop_low_d = stop_low_q | ~bit_value;
            any_one_d  = any_one_q | bit_value;
            stop_cnt_d = 1'b1;
          end
        end
      end
      StWaitHigh: begin
        cnt_clr = 1'b1;
        if (sync2_q) state_d = StIdle;
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      any_one_q  <= 1'b0;
      stop_low_q <= 1'b0;
      par_bad_q  <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= serialIn;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      any_one_q  <= any_one_d;
      stop_low_q <= stop_low_d;
      par_bad_q  <= par_bad_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      valid_q    <= valid_d;
      busy_q     <= (state_d != StIdle);
    end
  end

  assign dataOut       = data_q;
  assign dataValid     = valid_q;
  assign parityError   = perr_q;
  assign framingError  = ferr_q;
  assign breakDetected = brk_q;
  assign rxBusy        = busy_q;

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have parameter CLOCKS_POR_BIT, default 5209: clock cycles per bit slot; legal values are 4 or more.
REQ-002 The block SHALL have parameter DATA_BITS, default 8: data bits per frame; legal values are 5 to 9.
REQ-003 The block SHALL have parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 The block SHALL have parameter STOP_BITS, default 1: legal values are 1 or 2.
REQ-005 Port clock, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port serialIn, input, 1 bit: asynchronous serial line; idle level is high.
REQ-008 Port dataOut, output, DATA_BITS wide: last received data word, LSB first on the wire.
REQ-009 Port dataValid, output, 1 bit: one-cycle pulse marking a completed frame.
REQ-010 Port parityError, output, 1 bit: parity mismatch for the last frame; always 0 when PARITY=0.
REQ-011 Port framingError, output, 1 bit: a stop bit of the last frame was sampled low.
REQ-012 Port breakDetected, output, 1 bit: the last frame was all-zero, including parity and stop bits.
REQ-013 Port rxBusy, output, 1 bit: high from start-edge detection until the block returns to IDLE.

Function
REQ-014 serialIn SHALL pass through a 2-flop synchronizer; both flops are preset to 1; all decisions use the second flop.
REQ-015 Bit slot timing SHALL use a counter running 0..CLOCKS_POR_BIT-1; counter width is clog2(CLOCKS_POR_BIT); slot 0 (the start bit) begins on the first cycle the synchronized line is low in IDLE.
REQ-016 Each slot SHALL be sampled at counts M-1, M and M+1, where M=(CLOCKS_POR_BIT-1)/2; the bit value is the 2-of-3 majority.
REQ-017 The state machine SHALL have states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH; the encoding is fixed in the package.
REQ-018 IDLE -> START on a synchronized low.
REQ-019 In START, at count M+1: if the majority is 1, the block treats it as a false start and goes to IDLE with no pulse; otherwise it continues to DATA at the end of the slot.
REQ-020 In DATA, the block SHALL shift in DATA_BITS slots LSB first, then go to PARITY if PARITY!=0, otherwise to STOP.
REQ-021 In PARITY, the block SHALL compare the sampled bit against the XOR of the data bits (even) or its inverse (odd).
REQ-022 In STOP, the block SHALL evaluate STOP_BITS slots; the last stop slot is decided at count M+1, not at the end of the slot, so the block resynchronizes early.
REQ-023 On that last stop decision: dataOut, parityError, framingError and breakDetected SHALL update, and dataValid SHALL pulse on the next cycle (registered).
REQ-024 dataOut and the error flags SHALL hold their values until the next frame completes.
REQ-025 Next state after the last stop decision: IDLE if every stop sample was 1; WAIT_HIGH if framingError is set.
REQ-026 WAIT_HIGH SHALL stay until the synchronized line is high, then go to IDLE, so a line held low does not retrigger reception.
REQ-027 A break frame SHALL set both breakDetected and framingError; dataOut is 0 for a break frame.
REQ-028 With STOP_BITS=2, a low sample in either stop slot SHALL set framingError.
REQ-029 A single-cycle glitch on any one of the 3 sample points SHALL NOT change the decided bit value.
REQ-030 Back-to-back frames SHALL be accepted: a start edge arriving immediately after the decision point of the last stop bit is detected without loss.

Reset
REQ-031 While reset is high, the block SHALL go to IDLE, clear the counter and shift register, and preset the synchronizer flops to 1.
REQ-032 While reset is high, dataOut, dataValid, parityError, framingError, breakDetected and rxBusy SHALL all be 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no dataValid pulse; reception restarts on the first falling edge after reset is released.

Structure
REQ-034 Shared package uart_pkg SHALL hold the state encoding, the parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN, and the majority-of-3 function.
REQ-035 Sub-module uart_rx_sampler SHALL contain the slot counter, the 3-point sample capture and the majority vote, and SHALL output bitValue, midDone (count M+1) and slotEnd strobes.
REQ-036 The top level SHALL contain the FSM, the shift register, the parity accumulator and the output registers.

Verification (CLOCKS_POR_BIT=16)
REQ-037 8N1 frame 0xA5 -> dataOut=0xA5, one dataValid pulse, all error flags 0.
REQ-038 PARITY=2, data 0x07 sent with parity bit 0 -> dataOut=0x07, parityError=1; the same data with parity bit 1 -> parityError=0.
REQ-039 Line low for 3 cycles then high -> no dataValid, rxBusy returns to 0, and a following 0x3C frame is received correctly.
REQ-040 Stop bit driven low, then line held low for 100 cycles -> framingError=1, block stays in WAIT_HIGH, and no second dataValid until the line returns high.
REQ-041 Frame 0x00 with stop low -> breakDetected=1, framingError=1, dataOut=0x00; separately, a 1-cycle low glitch at count M of data bit 3 in 0xFF -> dataOut=0xFF.
REQ-042 Reset pulsed during data bit 4 of 0x55, then frame 0x3C -> no pulse for the aborted frame, then dataOut=0x3C; two back-to-back 0x12 and 0x34 frames -> two pulses, both values correct.
